// File: rtl/pulp_clock_gate_ctrl_pkg.sv
// pulp_clock_gate_ctrl_pkg: shared types and constants for the clock-gate sequencer.
package pulp_clock_gate_ctrl_pkg;

    typedef enum logic [1:0] {CG_OFF, CG_WAKE, CG_ON, CG_IDLE} cg_state_e;

    localparam cg_state_e CG_RESET_STATE = CG_ON;

    function automatic int cg_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulp_clock_gate_ctrl_chan.sv
// pulp_clock_gate_ctrl_chan: one gated domain (FSM, wake/idle counter, optional synchronizer).
// Define CLK_GATE_CTRL_SYNC_EN to pass req_i/busy_i through 2-flop synchronizers.
module pulp_clock_gate_ctrl_chan
    import pulp_clock_gate_ctrl_pkg::*;
#(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic req_i,
    input  logic busy_i,
    output logic en_o,
    output logic ack_o
);

    localparam int CW = $clog2(cg_max(WAKE_CYCLES, IDLE_CYCLES) + 1);
    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYCLES - 1);

    cg_state_e     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_en;
    logic          r_ack;
    logic          w_wake;

`ifdef CLK_GATE_CTRL_SYNC_EN
    logic [1:0] r_req_sync;
    logic [1:0] r_busy_sync;

    // Flops reset high so an active domain is not dropped right after reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_req_sync  <= '1;
            r_busy_sync <= '1;
        end else begin
            r_req_sync  <= {r_req_sync[0], req_i};
            r_busy_sync <= {r_busy_sync[0], busy_i};
        end
    end

    assign w_wake = r_req_sync[1] | r_busy_sync[1];
`else
    assign w_wake = req_i | busy_i;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= CG_RESET_STATE;
            r_cnt   <= '0;
            r_en    <= 1'b1;
            r_ack   <= 1'b1;
        end else begin
            case (r_state)
                CG_OFF: if (w_wake) begin
                    r_state <= CG_WAKE;
                    r_cnt   <= WAKE_LOAD;
                    r_en    <= 1'b1;
                end
                CG_WAKE: if (r_cnt == '0) begin
                    r_state <= CG_ON;
                    r_ack   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                CG_ON: if (!w_wake) begin
                    r_state <= CG_IDLE;
                    r_cnt   <= IDLE_LOAD;
                end
                CG_IDLE: if (w_wake) begin
                    r_state <= CG_ON;
                end else if (r_cnt == '0) begin
                    r_state <= CG_OFF;
                    r_en    <= 1'b0;
                    r_ack   <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                default: begin
                    r_state <= CG_RESET_STATE;
                    r_en    <= 1'b1;
                    r_ack   <= 1'b1;
                end
            endcase
        end
    end

    assign en_o  = r_en;
    assign ack_o = r_ack;

endmodule

// File: rtl/pulp_clock_gate_ctrl.sv
// pulp_clock_gate_ctrl: per-domain clock-gate sequencer driving pulp_clock_gating E inputs.
// Define CLK_GATE_CTRL_SYNC_EN for asynchronous req_i/busy_i (adds 2 cycles of latency).
module pulp_clock_gate_ctrl #(
    parameter int N_DOMAINS   = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 test_en_i,
    input  logic [N_DOMAINS-1:0] req_i,
    input  logic [N_DOMAINS-1:0] busy_i,
    output logic [N_DOMAINS-1:0] gate_en_o,
    output logic [N_DOMAINS-1:0] ack_o,
    output logic                 gated_o
);

    logic [N_DOMAINS-1:0] w_en;

    for (genvar i = 0; i < N_DOMAINS; i++) begin : g_chan
        pulp_clock_gate_ctrl_chan #(
            .WAKE_CYCLES(WAKE_CYCLES),
            .IDLE_CYCLES(IDLE_CYCLES)
        ) u_chan (
            .clk_i (clk_i),
            .rstn_i(rstn_i),
            .req_i (req_i[i]),
            .busy_i(busy_i[i]),
            .en_o  (w_en[i]),
            .ack_o (ack_o[i])
        );
    end

    // DFT override is deliberately combinational so scan sees running clocks at once.
    assign gate_en_o = w_en | {N_DOMAINS{test_en_i}};
    assign gated_o   = ~&gate_en_o;

endmodule

// File: doc/pulp_clock_gate_ctrl.md
# pulp_clock_gate_ctrl

Per-domain clock-gate sequencer. It drives the `E` input of N `pulp_clock_gating` cells, one per gated domain. A domain's gate opens on request or activity, and `ack` is returned once the gated clock has settled. The gate closes again after a programmable idle hysteresis. The block sits in the SoC clock/power control next to the clock-gate cells and runs on the ungated clock.

## Interface
Parameters:
- `N_DOMAINS`, default 4: number of gated domains (1..32).
- `WAKE_CYCLES`, default 2: cycles the gate is open before `ack_o` asserts (≥1).
- `IDLE_CYCLES`, default 16: consecutive idle cycles in ON before the gate closes (≥1).

Ports:
- `clk_i` in, 1: ungated source clock.
- `rstn_i` in, 1: asynchronous active-low reset.
- `test_en_i` in, 1: DFT override; forces every `gate_en_o` bit high.
- `req_i` in, N_DOMAINS: explicit clock request per domain (level).
- `busy_i` in, N_DOMAINS: domain activity indicator (level).
- `gate_en_o` out, N_DOMAINS: connects to the gate cell `E` input.
- `ack_o` out, N_DOMAINS: the domain's clock is running and stable.
- `gated_o` out, 1: OR-reduction of `~gate_en_o`, i.e. at least one domain is gated.

## Operation
- The channels are independent and identical. `wake[i] = req_i[i] | busy_i[i]`, sampled after the optional synchronizer.
- Each channel has its own FSM with four states:
  - OFF: `en=0`, `ack=0`. If `wake` → WAKE, with the counter loaded to `WAKE_CYCLES-1`.
  - WAKE: `en=1`, `ack=0`. The counter decrements; when it reaches 0 → ON. `wake` dropping during WAKE has no effect; the channel always completes to ON.
  - ON: `en=1`, `ack=1`. If `!wake` → IDLE, with the counter loaded to `IDLE_CYCLES-1`.
  - IDLE: `en=1`, `ack=1`.
    - If `wake` → ON. This takes priority and needs no re-wake delay.
    - Otherwise, if the counter is 0 → OFF; else the counter decrements.
- Outputs:
  - `gate_en_o[i] = (state != OFF) | test_en_i`. The FSM part is registered.
  - `ack_o[i] = state ∈ {ON, IDLE}`, registered. `ack_o` is not affected by `test_en_i`.
- Counter width is `$clog2(max(WAKE_CYCLES,IDLE_CYCLES)+1)`. The counter saturates at 0 and never wraps.
- Reset: every channel goes to ON, with `gate_en_o` all 1, `ack_o` all 1 and `gated_o` 0. Clocks run out of reset.
- A reset asserted mid-sequence (WAKE or IDLE) returns the channel to ON asynchronously.

## Timing
Counts below are without the synchronizer.
- Wake: `wake` is high at edge t, in OFF → `gate_en_o` is high after edge t+1 and `ack_o` is high after edge t+1+WAKE_CYCLES.
- Sleep: `wake` goes low at edge t, in ON → state is IDLE from t+1 and `gate_en_o` falls after edge t+1+IDLE_CYCLES. The low `wake` must persist through the whole window.
- `test_en_i` → `gate_en_o` is a combinational path of zero cycles.
- `ack_o` never precedes `gate_en_o` and always falls in the same cycle as `gate_en_o`.

## Configuration
- `CLK_GATE_CTRL_SYNC_EN` defined:
  - `req_i` and `busy_i` each pass through a 2-flop synchronizer per bit. The synchronizer flops reset to 1.
  - Every wake and sleep latency grows by 2 cycles.
  - The inputs may then be fully asynchronous.
- Not defined: the inputs are used directly and must be synchronous to `clk_i`.

## Structure
- Package `pulp_clock_gate_ctrl_pkg`:
  - `typedef enum logic [1:0] {CG_OFF, CG_WAKE, CG_ON, CG_IDLE} cg_state_e`.
  - Reset state constant `CG_RESET_STATE = CG_ON`.
- Sub-module `pulp_clock_gate_ctrl_chan`: one channel, holding the FSM, the counter and the optional synchronizer. It is instantiated N_DOMAINS times in a generate loop.
- The top level holds only the generate loop, the `test_en_i` OR and the `gated_o` reduction.

## Test plan
Defaults unless stated: N_DOMAINS=4, WAKE=2, IDLE=16, no sync.
1. Reset release with all inputs 0 → `gate_en_o=4'hF`, `ack_o=4'hF`; after 17 cycles `gate_en_o=4'h0`, `ack_o=4'h0`, `gated_o=1`.
2. From OFF, pulse `req_i[1]` for 1 cycle → `gate_en_o[1]` rises 1 cycle later and `ack_o[1]` 3 cycles after the pulse. IDLE then runs and the gate closes 16 cycles after entering IDLE.
3. In IDLE with the counter at 5, assert `busy_i[2]` → the state returns to ON, `gate_en_o[2]` and `ack_o[2]` stay 1 continuously, and the counter reloads on the next idle.
4. With all domains OFF, set `test_en_i=1` → `gate_en_o=4'hF` in the same cycle, `ack_o=4'h0`. Clear it → back to 0.
5. Assert `rstn_i` low while channel 0 is in WAKE → `gate_en_o[0]=1` and `ack_o[0]=1` immediately (asynchronously).
6. Rebuild with `CLK_GATE_CTRL_SYNC_EN` and repeat scenario 2 → `gate_en_o[1]` rises 3 cycles after the pulse and `ack_o[1]` 5 cycles after.
